wshb_arbiter: RTL and testbench

//  Two-master, round-robin, non-preemptive Wishbone arbiter sharing the single SDRAM Wishbone slave

---
 rtl/wshb_arbiter_if.sv | 29 ++
 rtl/wshb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wshb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_arbiter_if.sv
// Wishbone bus bundle shared by the SDRAM arbiter, its two masters and the SDRAM slave.
// Only the bus signals are carried; timing comes from the blocks that use it.
interface wshb_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32
) ();
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_W-1:0]       adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wshb_arbiter.sv
// Two-master round-robin, non-preemptive Wishbone arbiter in front of the SDRAM slave.
// state | meaning
// IDLE  | no grant, slave side held quiet
// GNT0  | master 0 (video reader) owns the slave until it drops cyc
// GNT1  | master 1 (writer) owns the slave until it drops cyc
module wshb_arbiter #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  wshb_if.slave            wshb_ifs0,
  wshb_if.slave            wshb_ifs1,
  wshb_if.master           wshb_ifm,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic                    cyc_mux;
  logic                    stb_mux;
  logic                    we_mux;
  logic [ADDR_W-1:0]       adr_mux;
  logic [8*DATA_BYTES-1:0] dat_mux;
  logic [DATA_BYTES-1:0]   sel_mux;
  logic [2:0]              cti_mux;
  logic [1:0]              bte_mux;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT0 && state != GNT0) begin
        last   <= 1'b0;
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
      if (state_nxt == GNT1 && state != GNT1) begin
        last   <= 1'b1;
        cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  // A releasing master is never re-granted while the other waits: the other
  // master's cyc is checked first on release.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wshb_ifs0.cyc && wshb_ifs1.cyc) state_nxt = last ? GNT0 : GNT1;
        else if (wshb_ifs0.cyc)             state_nxt = GNT0;
        else if (wshb_ifs1.cyc)             state_nxt = GNT1;
      end
      GNT0: begin
        if (!wshb_ifs0.cyc) state_nxt = wshb_ifs1.cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (!wshb_ifs1.cyc) state_nxt = wshb_ifs0.cyc ? GNT0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    we_mux  = 1'b0;
    adr_mux = '0;
    dat_mux = '0;
    sel_mux = '0;
    cti_mux = '0;
    bte_mux = '0;
    wshb_ifs0.ack = 1'b0;
    wshb_ifs0.err = 1'b0;
    wshb_ifs0.rty = 1'b0;
    wshb_ifs1.ack = 1'b0;
    wshb_ifs1.err = 1'b0;
    wshb_ifs1.rty = 1'b0;
    case (state)
      GNT0: begin
        cyc_mux = wshb_ifs0.cyc;
        stb_mux = wshb_ifs0.stb;
        we_mux  = wshb_ifs0.we;
        adr_mux = wshb_ifs0.adr;
        dat_mux = wshb_ifs0.dat_ms;
        sel_mux = wshb_ifs0.sel;
        cti_mux = wshb_ifs0.cti;
        bte_mux = wshb_ifs0.bte;
        wshb_ifs0.ack = wshb_ifm.ack;
        wshb_ifs0.err = wshb_ifm.err;
        wshb_ifs0.rty = wshb_ifm.rty;
      end
      GNT1: begin
        cyc_mux = wshb_ifs1.cyc;
        stb_mux = wshb_ifs1.stb;
        we_mux  = wshb_ifs1.we;
        adr_mux = wshb_ifs1.adr;
        dat_mux = wshb_ifs1.dat_ms;
        sel_mux = wshb_ifs1.sel;
        cti_mux = wshb_ifs1.cti;
        bte_mux = wshb_ifs1.bte;
        wshb_ifs1.ack = wshb_ifm.ack;
        wshb_ifs1.err = wshb_ifm.err;
        wshb_ifs1.rty = wshb_ifm.rty;
      end
      default: ;
    endcase
  end

  assign wshb_ifm.cyc    = cyc_mux;
  assign wshb_ifm.stb    = stb_mux;
  assign wshb_ifm.we     = we_mux;
  assign wshb_ifm.adr    = adr_mux;
  assign wshb_ifm.dat_ms = dat_mux;
  assign wshb_ifm.sel    = sel_mux;
  assign wshb_ifm.cti    = cti_mux;
  assign wshb_ifm.bte    = bte_mux;

  // Read data is broadcast; only the granted master sees ack to qualify it.
  assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

  assign grant = state;
  assign cnt0  = cnt0_q;
  assign cnt1  = cnt1_q;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench for the two-master SDRAM Wishbone arbiter.
module tb_wshb_arbiter;
  logic        sys_clk;
  logic        sys_rst_n;
  logic [1:0]  grant;
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  int          checks;
  int          errors;

  wshb_if #(.DATA_BYTES(4), .ADDR_W(32)) s0_if ();
  wshb_if #(.DATA_BYTES(4), .ADDR_W(32)) s1_if ();
  wshb_if #(.DATA_BYTES(4), .ADDR_W(32)) m_if ();

  wshb_arbiter #(.DATA_BYTES(4), .ADDR_W(32), .CNT_W(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wshb_ifs0 (s0_if.slave),
    .wshb_ifs1 (s1_if.slave),
    .wshb_ifm  (m_if.master),
    .grant     (grant),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.cyc = 0; s0_if.stb = 0; s0_if.we = 0; s0_if.adr = '0;
    s0_if.dat_ms = '0; s0_if.sel = '0; s0_if.cti = '0; s0_if.bte = '0;
    s1_if.cyc = 0; s1_if.stb = 0; s1_if.we = 0; s1_if.adr = '0;
    s1_if.dat_ms = '0; s1_if.sel = '0; s1_if.cti = '0; s1_if.bte = '0;
    m_if.ack = 0; m_if.err = 0; m_if.rty = 0; m_if.dat_sm = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    sys_rst_n = 0;
    tick();
    tick();
    sys_rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    sys_rst_n = 0;
    m_if.ack = 1; m_if.err = 1;
    s0_if.cyc = 1; s0_if.stb = 1;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (m_if.cyc !== 1'b0 || m_if.stb !== 1'b0 || m_if.we !== 1'b0) begin errors++; $display("FAIL reset_slave_cyc got %b%b%b exp 000", m_if.cyc, m_if.stb, m_if.we); end
    checks++; if (s0_if.ack !== 1'b0 || s0_if.err !== 1'b0 || s1_if.ack !== 1'b0) begin errors++; $display("FAIL reset_acks got %b%b%b exp 000", s0_if.ack, s0_if.err, s1_if.ack); end
    checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt got %h/%h exp 0/0", cnt0, cnt1); end
    clear_inputs();
    sys_rst_n = 1;
    tick();
  endtask

  task automatic test_single_read();
    apply_reset();
    s0_if.cyc = 1; s0_if.stb = 1; s0_if.adr = 32'h0000_0100; s0_if.sel = 4'hF;
    #1;
    checks++; if (m_if.cyc !== 1'b0) begin errors++; $display("FAIL single_pre_cyc got %b exp 0", m_if.cyc); end
    tick();
    checks++; if (grant !== 2'b01 || m_if.cyc !== 1'b1) begin errors++; $display("FAIL single_grant got %b cyc %b exp 01 cyc 1", grant, m_if.cyc); end
    checks++; if (m_if.adr !== 32'h0000_0100 || m_if.sel !== 4'hF) begin errors++; $display("FAIL single_adr got %h/%h exp 100/F", m_if.adr, m_if.sel); end
    m_if.ack = 1; m_if.dat_sm = 32'hCAFE_F00D;
    #1;
    checks++; if (s0_if.ack !== 1'b1 || s1_if.ack !== 1'b0) begin errors++; $display("FAIL single_ack got %b/%b exp 1/0", s0_if.ack, s1_if.ack); end
    checks++; if (s0_if.dat_sm !== 32'hCAFE_F00D || s1_if.dat_sm !== 32'hCAFE_F00D) begin errors++; $display("FAIL single_dat got %h/%h exp cafef00d", s0_if.dat_sm, s1_if.dat_sm); end
    checks++; if (cnt0 !== 16'd1 || cnt1 !== 16'd0) begin errors++; $display("FAIL single_cnt got %0d/%0d exp 1/0", cnt0, cnt1); end
    tick();
    m_if.ack = 0; s0_if.cyc = 0; s0_if.stb = 0;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle got %b exp 00", grant); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    s0_if.cyc = 1; s0_if.stb = 1; s1_if.cyc = 1; s1_if.stb = 1;
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first got %b exp 01", grant); end
    s0_if.cyc = 0; s0_if.stb = 0;
    #1;
    checks++; if (m_if.cyc !== 1'b0) begin errors++; $display("FAIL tie_dead_cycle got %b exp 0", m_if.cyc); end
    tick();
    checks++; if (grant !== 2'b10 || m_if.cyc !== 1'b1) begin errors++; $display("FAIL tie_handover got %b cyc %b exp 10 cyc 1", grant, m_if.cyc); end
    checks++; if (cnt0 !== 16'd1 || cnt1 !== 16'd1) begin errors++; $display("FAIL tie_cnt got %0d/%0d exp 1/1", cnt0, cnt1); end
    s1_if.cyc = 0; s1_if.stb = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    apply_reset();
    s0_if.cyc = 1; s0_if.stb = 1; s1_if.cyc = 1; s1_if.stb = 1;
    tick();
    exp_g = 2'b01;
    for (int r = 0; r < 4; r++) begin
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_round%0d got %b exp %b", r, grant, exp_g); end
      m_if.ack = 1;
      for (int b = 0; b < 4; b++) begin
        #1;
        checks++;
        if ((exp_g == 2'b01 && (s0_if.ack !== 1'b1 || s1_if.ack !== 1'b0)) ||
            (exp_g == 2'b10 && (s1_if.ack !== 1'b1 || s0_if.ack !== 1'b0))) begin
          errors++; $display("FAIL rr_ack r%0d b%0d got %b/%b", r, b, s0_if.ack, s1_if.ack);
        end
        tick();
      end
      m_if.ack = 0;
      if (exp_g == 2'b01) begin s0_if.cyc = 0; s0_if.stb = 0; end
      else begin s1_if.cyc = 0; s1_if.stb = 0; end
      tick();
      s0_if.cyc = 1; s0_if.stb = 1; s1_if.cyc = 1; s1_if.stb = 1;
      exp_g = (exp_g == 2'b01) ? 2'b10 : 2'b01;
    end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_final got %b exp 01", grant); end
    checks++; if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin errors++; $display("FAIL rr_cnt got %0d/%0d exp 3/2", cnt0, cnt1); end
    clear_inputs();
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle got %b exp 00", grant); end
  endtask

  task automatic test_burst();
    logic [2:0]  exp_cti;
    logic [31:0] exp_adr;
    apply_reset();
    s1_if.cyc = 1; s1_if.stb = 1; s1_if.we = 1; s1_if.cti = 3'b010; s1_if.bte = 2'b00;
    s1_if.adr = 32'h0000_2000;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL burst_grant got %b exp 10", grant); end
    for (int b = 0; b < 8; b++) begin
      exp_cti = (b == 7) ? 3'b111 : 3'b010;
      exp_adr = 32'h0000_2000 + 32'(4 * b);
      s1_if.cti = exp_cti; s1_if.adr = exp_adr; s1_if.dat_ms = 32'(b);
      if (b == 2) begin s0_if.cyc = 1; s0_if.stb = 1; end
      m_if.ack = 1;
      #1;
      checks++;
      if (grant !== 2'b10 || m_if.cyc !== 1'b1 || m_if.we !== 1'b1 || m_if.cti !== exp_cti ||
          m_if.adr !== exp_adr || m_if.dat_ms !== 32'(b) || s1_if.ack !== 1'b1 || s0_if.ack !== 1'b0) begin
        errors++;
        $display("FAIL burst_beat%0d got g=%b cyc=%b cti=%b adr=%h ack=%b/%b exp g=10 cti=%b adr=%h ack=0/1",
                 b, grant, m_if.cyc, m_if.cti, m_if.adr, s0_if.ack, s1_if.ack, exp_cti, exp_adr);
      end
      tick();
    end
    m_if.ack = 0; s1_if.cyc = 0; s1_if.stb = 0; s1_if.we = 0;
    #1;
    checks++; if (m_if.cyc !== 1'b0 || s0_if.ack !== 1'b0) begin errors++; $display("FAIL burst_dead got cyc %b ack0 %b exp 0/0", m_if.cyc, s0_if.ack); end
    tick();
    checks++; if (grant !== 2'b01 || cnt0 !== 16'd1 || cnt1 !== 16'd1) begin errors++; $display("FAIL burst_handover got %b %0d/%0d exp 01 1/1", grant, cnt0, cnt1); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    s1_if.cyc = 1; s1_if.stb = 1;
    tick();
    checks++; if (grant !== 2'b10 || m_if.cyc !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b cyc %b exp 10/1", grant, m_if.cyc); end
    #2;
    sys_rst_n = 0;
    #1;
    checks++; if (m_if.cyc !== 1'b0 || m_if.stb !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rstmid_async got cyc %b g %b exp 0/00", m_if.cyc, grant); end
    clear_inputs();
    tick();
    sys_rst_n = 1;
    tick();
    checks++; if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || grant !== 2'b00) begin errors++; $display("FAIL rstmid_post got %0d/%0d g %b exp 0/0 00", cnt0, cnt1, grant); end
  endtask

  task automatic test_err();
    apply_reset();
    s0_if.cyc = 1; s0_if.stb = 1;
    tick();
    m_if.err = 1;
    #1;
    checks++; if (s0_if.err !== 1'b1 || s1_if.err !== 1'b0 || s0_if.ack !== 1'b0) begin errors++; $display("FAIL err_route got %b/%b exp 1/0", s0_if.err, s1_if.err); end
    s1_if.cyc = 1; s1_if.stb = 1;
    tick();
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL err_hold got %b exp 01", grant); end
    m_if.err = 0; m_if.rty = 1;
    #1;
    checks++; if (s0_if.rty !== 1'b1 || s1_if.rty !== 1'b0) begin errors++; $display("FAIL rty_route got %b/%b exp 1/0", s0_if.rty, s1_if.rty); end
    m_if.rty = 0; s0_if.cyc = 0; s0_if.stb = 0;
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL err_release got %b exp 10", grant); end
    clear_inputs();
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    force dut.cnt1_q = 16'hFFFF;
    #1;
    release dut.cnt1_q;
    #1;
    checks++; if (cnt1 !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got %h exp ffff", cnt1); end
    s1_if.cyc = 1; s1_if.stb = 1;
    tick();
    checks++; if (cnt1 !== 16'h0000 || cnt0 !== 16'h0000 || grant !== 2'b10) begin errors++; $display("FAIL wrap_cnt got %h/%h g %b exp 0000/0000 10", cnt1, cnt0, grant); end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    sys_rst_n = 0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_back_to_back();
    test_burst();
    test_reset_mid();
    test_err();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
